spi_register_hub: RTL
=====================

// Module: spi_register_hub
// PURPOSE
//  Parametrised SPI-slave register hub: N output ctrl regs, M input status regs, sticky masked irq.
//  Generalises the fixed FPGA register slave: parametrised depth, burst auto-increment, W1C interrupts.
//  Sits between the selected SPI chip select (spi_cs_n) and the audio/sram/mpio/aux datapaths.
// PARAMETERS
//  NUM_OUT_REGS  8      R/W output registers at addr 0x00..NUM_OUT_REGS-1 (1..64)
//  NUM_IN_REGS   4      read-only input registers at addr 0x40..0x40+NUM_IN_REGS-1 (1..60)
//  INT_WIDTH     8      interrupt sources (1..8)
//  AUTO_INC      1      1: address increments after each data byte; 0: fixed address
//  VERSION       8'h01  value returned at ID addr 0x7F
// PORTS
//  clk          in   1               system clock, >= 8x spi_clk
//  reset        in   1               synchronous, active-high
//  spi_cs_n     in   1               async, active-low frame select
//  spi_clk      in   1               async SPI clock, mode 0
//  spi_mosi     in   1               async serial data in
//  spi_miso     out  1               serial data out; 0 when spi_miso_oe=0
//  spi_miso_oe  out  1               high while frame active and read in progress
//  in_regs      in   8*NUM_IN_REGS   flat input regs; reg k = [8k+7:8k]
//  out_regs     out  8*NUM_OUT_REGS  flat output regs; reg k = [8k+7:8k]
//  reg_addr     out  7               address of current/last access
//  wr_stb       out  1               1-clk pulse per completed write byte
//  rd_stb       out  1               1-clk pulse when a read byte is loaded to shifter
//  int_src      in   INT_WIDTH       async level interrupt sources
//  irq          out  1               |(int_status & int_mask), registered
// BEHAVIOUR
//  Reset: out_regs/reg_addr/int_status/int_mask = 0; spi_miso/spi_miso_oe/wr_stb/rd_stb/irq = 0; FSM IDLE.
//  spi_cs_n/spi_clk/spi_mosi/int_src: 2-FF sync to clk; spi_clk edges detected from synced copy.
//  Frame: byte0 = {rw, addr[6:0]}, rw=1 read; following bytes are data, MSB first.
//  FSM: IDLE -(cs low)-> CMD -(8 bits)-> WDATA or RDATA; any state -(cs high)-> IDLE.
//  CMD: latch addr into reg_addr on 8th rising edge; if read, load shifter, pulse rd_stb, set oe.
//  RDATA: MISO updated on each synced spi_clk falling edge; bit7 valid before 1st data rising edge.
//    After 8th bit: if AUTO_INC, reg_addr = (reg_addr+1) mod 128; reload shifter, pulse rd_stb.
//  WDATA: after 8th rising edge: pulse wr_stb; out reg updated same cycle; addr inc as above.
//  wr_stb asserted <= 4 clk after 8th data-bit spi_clk rising edge at pins.
//  Map: 0x00+k out reg k (R/W); 0x40+k in_regs k (RO, sampled at shifter load);
//    0x7C int_status (R, W1C); 0x7D int_mask (R/W); 0x7E synced int_src (RO); 0x7F VERSION (RO).
//  Unmapped read -> 8'h00; write to unmapped/RO addr -> ignored, wr_stb still pulses.
//  Bits above INT_WIDTH read 0, writes ignored.
//  Address wrap 0x7F -> 0x00 in bursts; no error.
//  cs_n high mid-byte: partial byte discarded, no strobe, oe low next clk, bit counter cleared.
//  int_status[i] set on synced rising edge of int_src[i]; sticky until W1C.
//  Simultaneous set and W1C clear of same bit: set wins.
//  irq registered: 1 clk after int_status/int_mask change.
//  reset during frame: FSM to IDLE, all regs to reset values; rest of frame ignored until cs_n high.
// TESTING
//  T1 write 0x02,0xA5 -> out_regs[23:16]=8'hA5; one wr_stb, reg_addr=2; other regs 0.
//  T2 in_regs reg1=8'h3C; read 0x41 -> MISO 8'h3C; rd_stb x1; oe low after cs_n high.
//  T3 burst write 0x06,11,22,33 (NUM_OUT_REGS=8) -> reg6=11, reg7=22, addr 0x08 ignored; 3 wr_stb.
//  T4 int_src[2] 0->1, mask=0x04 -> status 0x04, irq=1; W1C 0x04 -> irq 0; clear-same-cycle-as-edge keeps bit set.
//  T5 cs_n high after 5 data bits of a write to 0x01 -> no wr_stb, reg1 unchanged; next frame decodes.
//  T6 reset mid burst read -> all outputs 0 next clk; read 0x7F after -> 8'h01.

Source files
------------

// File: rtl/spi_register_hub.sv
// spi_register_hub: SPI mode-0 slave exposing a small register map.
// Output control registers, read-only input registers, a sticky masked
// interrupt block and a version ID. All SPI pins and interrupt sources are
// brought into the clk domain through 2-FF synchronisers. SPI clock edges
// are detected from the synchronised copy.
module spi_register_hub #(
    parameter int         NUM_OUT_REGS = 8,
    parameter int         NUM_IN_REGS  = 4,
    parameter int         INT_WIDTH    = 8,
    parameter bit         AUTO_INC     = 1'b1,
    parameter logic [7:0] VERSION      = 8'h01
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_cs_n,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    input  logic [8*NUM_IN_REGS-1:0]  in_regs,
    output logic [8*NUM_OUT_REGS-1:0] out_regs,
    output logic [6:0]                reg_addr,
    output logic                      wr_stb,
    output logic                      rd_stb,
    input  logic [INT_WIDTH-1:0]      int_src,
    output logic                      irq
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

    state_t               state;
    logic [2:0]           bit_cnt;
    logic [6:0]           shift_in;
    logic [7:0]           shift_out;

    logic                 cs_n_p0, cs_n_p1, cs_n_p2;
    logic                 sclk_p0, sclk_p1, sclk_p2;
    logic                 mosi_p0, mosi_p1;
    logic [INT_WIDTH-1:0] int_p0, int_p1, int_p2;

    logic [INT_WIDTH-1:0] int_status;
    logic [INT_WIDTH-1:0] int_mask;

    logic                 sclk_rise, sclk_fall, cs_fall, byte_done, wr_fire;
    logic [7:0]           rx_byte;
    logic [6:0]           next_addr;
    logic [7:0]           cmd_rd, nxt_rd;
    logic [INT_WIDTH-1:0] int_rise, w1c;

    // Zero-extend an interrupt-width field to a register byte.
    function automatic logic [7:0] pad_int(input logic [INT_WIDTH-1:0] v);
        logic [7:0] r;
        r = '0;
        r[INT_WIDTH-1:0] = v;
        return r;
    endfunction

    // Register map read decode; unmapped addresses read as zero.
    function automatic logic [7:0] read_byte(input logic [6:0] a);
        int         idx;
        logic [7:0] r;
        idx = int'(a);
        r   = 8'h00;
        if (idx < NUM_OUT_REGS) begin
            r = out_regs[8*idx +: 8];
        end else if ((idx >= 64) && (idx < 64 + NUM_IN_REGS)) begin
            r = in_regs[8*(idx-64) +: 8];
        end else begin
            case (a)
                7'h7C:   r = pad_int(int_status);
                7'h7D:   r = pad_int(int_mask);
                7'h7E:   r = pad_int(int_p1);
                7'h7F:   r = VERSION;
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // Synchronise asynchronous pins; cs_n chain resets to "asserted" so a
    // frame already in progress at reset release is never mistaken for a new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_p0 <= 1'b0;
            cs_n_p1 <= 1'b0;
            cs_n_p2 <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            int_p0  <= '0;
            int_p1  <= '0;
            int_p2  <= '0;
        end else begin
            cs_n_p0 <= spi_cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            sclk_p0 <= spi_clk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            int_p0  <= int_src;
            int_p1  <= int_p0;
            int_p2  <= int_p1;
        end
    end

    // MOSI data synchroniser, aligned in depth with the spi_clk chain.
    always_ff @(posedge clk) begin
        mosi_p0 <= spi_mosi;
        mosi_p1 <= mosi_p0;
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = cs_n_p2 & ~cs_n_p1;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {shift_in, mosi_p1};
    assign next_addr = AUTO_INC ? reg_addr + 7'd1 : reg_addr;
    assign wr_fire   = (state == S_WDATA) && byte_done && !cs_n_p1;
    assign int_rise  = int_p1 & ~int_p2;
    assign w1c       = (wr_fire && (reg_addr == 7'h7C)) ? rx_byte[INT_WIDTH-1:0] : '0;

    // Read data for the command address and for the next burst address.
    always_comb begin
        cmd_rd = read_byte(rx_byte[6:0]);
        nxt_rd = read_byte(next_addr);
    end

    // Frame FSM: command decode, serial shifting, register writes and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            reg_addr    <= 7'd0;
            out_regs    <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (cs_n_p1) begin
                state       <= S_IDLE;
                bit_cnt     <= 3'd0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    shift_in <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_CMD: begin
                        if (byte_done) begin
                            reg_addr <= rx_byte[6:0];
                            if (rx_byte[7]) begin
                                state       <= S_RDATA;
                                shift_out   <= cmd_rd;
                                spi_miso    <= cmd_rd[7];
                                spi_miso_oe <= 1'b1;
                                rd_stb      <= 1'b1;
                            end else begin
                                state <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (byte_done) begin
                            wr_stb   <= 1'b1;
                            reg_addr <= next_addr;
                            if (int'(reg_addr) < NUM_OUT_REGS) begin
                                out_regs[8*int'(reg_addr) +: 8] <= rx_byte;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (byte_done) begin
                            reg_addr  <= next_addr;
                            shift_out <= nxt_rd;
                            spi_miso  <= nxt_rd[7];
                            rd_stb    <= 1'b1;
                        end else if (sclk_rise) begin
                            shift_out <= {shift_out[6:0], 1'b0};
                        end else if (sclk_fall) begin
                            spi_miso <= shift_out[7];
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky interrupt status with W1C (a new edge beats a clear), mask and registered irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_status <= '0;
            int_mask   <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_fire && (reg_addr == 7'h7D)) begin
                int_mask <= rx_byte[INT_WIDTH-1:0];
            end
            int_status <= (int_status & ~w1c) | int_rise;
            irq        <= |(int_status & int_mask);
        end
    end

endmodule
